s2p_slave: RTL and testbench
============================

S2P_SLAVE -- requirements
Module: s2p_slave

Interface
REQ-001 SHALL have parameter NBIT, default 64: frame width in bits, minimum 2.
REQ-002 SHALL have parameter DEF, default {NBIT{1'b0}}: po value after reset and after link loss.
REQ-003 SHALL have parameter TOUT, default 65535: clk cycles without a synchronized sclk edge before link loss, minimum 16.
REQ-004 SHALL have port clk, input, 1: single system clock; every flop is in this domain.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port si, input, 1: serial data from the p2s serializer; bit k is driven for a full sclk period.
REQ-007 SHALL have port sclk, input, 1: serial clock; asynchronous to clk; high half-period and low half-period are each at least 4 clk.
REQ-008 SHALL have port sld_n, input, 1: frame marker; it is low during the sclk period that carries bit 0.
REQ-009 SHALL have port po, output, NBIT: last validated parallel word; bit k equals the k-th serial bit.
REQ-010 SHALL have port po_vld, output, 1: one-clk pulse when po is updated.
REQ-011 SHALL have port frame_err, output, 1: one-clk pulse on a short or overlong frame.
REQ-012 SHALL have port link_ok, output, 1: level, high while valid frames are being received.

Function
REQ-013 SHALL pass si, sclk and sld_n through identical 3-flop synchronizers (si_s, sclk_s, sld_s) so the three stay mutually aligned.
REQ-014 SHALL detect a rise when sclk_s is 1 and its previous value was 0, and on that cycle SHALL sample si_s and sld_s; falling edges only restart the timeout.
REQ-015 SHALL implement states IDLE, SHIFT and DONE, together with a bit counter bcnt of width clogb2(NBIT+1).
REQ-016 SHALL, on a rise with sld_s=0 in any state, write shreg[0]=si_s, set bcnt=1 and go to SHIFT.
REQ-017 SHALL pulse frame_err if the rise in REQ-016 arrives while in SHIFT (short frame), and SHALL still restart the frame.
REQ-018 SHALL, on a rise with sld_s=1 in SHIFT, write shreg[bcnt]=si_s and increment bcnt.
REQ-019 SHALL treat the write of bit NBIT-1 as frame complete and go to DONE.
REQ-020 SHALL, on a rise with sld_s=1 in DONE (overlong frame), pulse frame_err, go to IDLE and clear cand_vld.
REQ-021 SHALL ignore a rise with sld_s=1 in IDLE.
REQ-022 SHALL, on frame complete, compare the new frame against cand.
REQ-023 SHALL, if cand_vld=1 and the frame equals cand, load po with the frame and pulse po_vld on the following clk.
REQ-024 SHALL, on every frame complete, set cand to the new frame and set cand_vld=1.
REQ-025 SHALL require two consecutive identical frames before po is updated; the first frame after reset, error or link loss never updates po.
REQ-026 SHALL clear cand_vld on frame_err; po keeps its value.
REQ-027 SHALL count clk cycles since the last synchronized sclk edge of either polarity, saturating at TOUT.
REQ-028 SHALL, when the count reaches TOUT: set link_ok=0, set po=DEF, go to IDLE and clear cand_vld; no po_vld pulse is issued.
REQ-029 SHALL set link_ok=1 together with each po_vld pulse.
REQ-030 SHALL give frame_err, when it coincides with the timeout, precedence for its pulse, while the timeout actions still apply.
REQ-031 SHALL update po no later than 6 clk after the sclk pin rise that carries bit NBIT-1.

Reset
REQ-032 SHALL, while rst_n=0, immediately force: po=DEF, po_vld=0, frame_err=0, link_ok=0, state IDLE, bcnt=0, shreg=0, cand=0, cand_vld=0, synchronizers=1'b1 for sld_n and 1'b0 for si/sclk, timeout count=0.
REQ-033 SHALL, when reset is asserted mid-frame, discard the partial frame; after release, reception restarts only on the next rise with sld_s=0.

Verification (NBIT=8, DEF=8'h00, TOUT=64, sclk half-period 8 clk)
REQ-034 SHALL cover: two frames 8'hA5 from a p2s model -> one po_vld pulse after the 2nd frame, po=8'hA5, link_ok=1, no frame_err.
REQ-035 SHALL cover: frames 8'h3C, 8'h3D, 8'h3D -> po_vld only after the 3rd frame, po=8'h3D.
REQ-036 SHALL cover: sld_n low again after 5 bits -> frame_err one pulse, po unchanged; the next two good 8'h11 frames give po=8'h11.
REQ-037 SHALL cover: sld_n held high for 10 bit periods after a frame -> frame_err at the 9th rise, state IDLE.
REQ-038 SHALL cover: sclk stopped for 70 clk after po=8'hA5 -> link_ok=0, po=8'h00 within 64+4 clk, no po_vld.
REQ-039 SHALL cover: rst_n pulsed low mid-frame -> all outputs at reset values; the first po_vld occurs only after two complete frames following release.

Source files
------------

// File: rtl/s2p_slave.sv
// Serial-to-parallel slave: deserialises sclk/si/sld_n frames and publishes a word only after two identical frames.
// po updates 4-5 clk after the sclk rise of the last bit; no backpressure, and frames arriving while busy are never stalled.
module s2p_slave #(
    parameter int              NBIT = 64,
    parameter logic [NBIT-1:0] DEF  = {NBIT{1'b0}},
    parameter int              TOUT = 65535
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            si,
    input  logic            sclk,
    input  logic            sld_n,
    output logic [NBIT-1:0] po,
    output logic            po_vld,
    output logic            frame_err,
    output logic            link_ok
);

    localparam int BW = $clog2(NBIT + 1);
    localparam int TW = $clog2(TOUT + 1);
    localparam logic [BW-1:0] LAST = BW'(NBIT - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state;
    logic [BW-1:0]   bcnt;
    logic [NBIT-1:0] shreg;
    logic [NBIT-1:0] cand;
    logic            cand_vld;
    logic [TW-1:0]   tcnt;

    logic [2:0] si_q;
    logic [2:0] sclk_q;
    logic [2:0] sld_q;
    logic       sclk_d;

    logic            si_s;
    logic            sclk_s;
    logic            sld_s;
    logic            rise;
    logic            sclk_edge;
    logic            tout_hit;
    logic [NBIT-1:0] frame_new;

    // Same depth on all three lines keeps data, clock and frame marker aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            si_q   <= 3'b000;
            sclk_q <= 3'b000;
            sld_q  <= 3'b111;
            sclk_d <= 1'b0;
        end else begin
            si_q   <= {si_q[1:0], si};
            sclk_q <= {sclk_q[1:0], sclk};
            sld_q  <= {sld_q[1:0], sld_n};
            sclk_d <= sclk_q[2];
        end
    end

    assign si_s      = si_q[2];
    assign sclk_s    = sclk_q[2];
    assign sld_s     = sld_q[2];
    assign rise      = sclk_s & ~sclk_d;
    assign sclk_edge = sclk_s ^ sclk_d;
    assign tout_hit  = !sclk_edge && (tcnt == TW'(TOUT - 1));
    assign frame_new = {si_s, shreg[NBIT-2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
        end else if (sclk_edge) begin
            tcnt <= '0;
        end else if (tcnt != TW'(TOUT)) begin
            tcnt <= tcnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bcnt      <= '0;
            shreg     <= '0;
            cand      <= '0;
            cand_vld  <= 1'b0;
            po        <= DEF;
            po_vld    <= 1'b0;
            frame_err <= 1'b0;
            link_ok   <= 1'b0;
        end else begin
            po_vld    <= 1'b0;
            frame_err <= 1'b0;

            if (rise) begin
                if (!sld_s) begin
                    // A new frame marker always restarts; mid-frame it means the old frame was short.
                    if (state == SHIFT) begin
                        frame_err <= 1'b1;
                        cand_vld  <= 1'b0;
                    end
                    shreg[0] <= si_s;
                    bcnt     <= BW'(1);
                    state    <= SHIFT;
                end else begin
                    case (state)
                        SHIFT: begin
                            for (int k = 0; k < NBIT; k++) begin
                                if (bcnt == BW'(k)) shreg[k] <= si_s;
                            end
                            bcnt <= bcnt + BW'(1);
                            if (bcnt == LAST) begin
                                state    <= DONE;
                                cand     <= frame_new;
                                cand_vld <= 1'b1;
                                if (cand_vld && (frame_new == cand)) begin
                                    po      <= frame_new;
                                    po_vld  <= 1'b1;
                                    link_ok <= 1'b1;
                                end
                            end
                        end
                        DONE: begin
                            frame_err <= 1'b1;
                            cand_vld  <= 1'b0;
                            state     <= IDLE;
                        end
                        default: begin
                        end
                    endcase
                end
            end

            // Link loss overrides the frame logic but leaves any frame_err pulse intact.
            if (tout_hit) begin
                link_ok  <= 1'b0;
                po       <= DEF;
                po_vld   <= 1'b0;
                state    <= IDLE;
                cand_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_s2p_slave.sv
// Directed bench for s2p_slave: p2s-style frame driver, cand model feeding an expected-po queue, po_vld monitor.
module tb_s2p_slave;

    localparam int         NBIT = 8;
    localparam logic [7:0] DEF  = 8'h00;
    localparam int         TOUT = 64;
    localparam int         HP   = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       si    = 1'b0;
    logic       sclk  = 1'b0;
    logic       sld_n = 1'b1;
    logic [7:0] po;
    logic       po_vld;
    logic       frame_err;
    logic       link_ok;

    always #5 clk = ~clk;

    s2p_slave #(.NBIT(NBIT), .DEF(DEF), .TOUT(TOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .si        (si),
        .sclk      (sclk),
        .sld_n     (sld_n),
        .po        (po),
        .po_vld    (po_vld),
        .frame_err (frame_err),
        .link_ok   (link_ok)
    );

    int         checks   = 0;
    int         errors   = 0;
    int         ferr_cnt = 0;
    int         vld_cnt  = 0;
    int         n_push   = 0;
    logic [7:0] sb[$];
    logic [7:0] m_cand     = 8'h00;
    bit         m_cand_vld = 1'b0;
    logic [7:0] exp_po;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (frame_err === 1'b1) ferr_cnt++;
        if (po_vld === 1'b1) begin
            vld_cnt++;
            check("po_vld_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                exp_po = sb.pop_front();
                check("po_value", po, exp_po);
                check("link_ok_with_vld", link_ok, 1'b1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic ld);
        sclk  = 1'b0;
        si    = b;
        sld_n = ld;
        tick(HP);
        sclk = 1'b1;
        tick(HP);
    endtask

    task automatic send_frame(input logic [7:0] d);
        bit exp_vld;
        int seen;
        exp_vld = m_cand_vld && (d == m_cand);
        if (exp_vld) begin
            sb.push_back(d);
            n_push++;
        end
        m_cand     = d;
        m_cand_vld = 1'b1;
        for (int k = 0; k < NBIT - 1; k++) send_bit(d[k], (k == 0) ? 1'b0 : 1'b1);
        sclk  = 1'b0;
        si    = d[7];
        sld_n = 1'b1;
        tick(HP);
        sclk = 1'b1;
        seen = 0;
        for (int i = 1; i <= HP; i++) begin
            tick(1);
            if (po_vld === 1'b1 && seen == 0) seen = i;
        end
        if (exp_vld) check("vld_latency", (seen >= 1) && (seen <= 6), 1'b1);
        else         check("no_vld_first_frame", seen, 0);
    endtask

    initial begin
        int         waited;
        int         vld_before;
        logic [7:0] junk;

        #2 rst_n = 1'b0;
        tick(3);
        check("rst_po", po, DEF);
        check("rst_po_vld", po_vld, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_link_ok", link_ok, 1'b0);
        rst_n = 1'b1;
        tick(4);

        // Two identical frames publish the word.
        send_frame(8'hA5);
        send_frame(8'hA5);
        check("a5_po", po, 8'hA5);
        check("a5_link_ok", link_ok, 1'b1);
        check("a5_no_ferr", ferr_cnt, 0);

        // Only the repeat of the latest frame counts.
        send_frame(8'h3C);
        send_frame(8'h3D);
        check("3d_hold_po", po, 8'hA5);
        send_frame(8'h3D);
        check("3d_po", po, 8'h3D);

        // Short frame: five bits then a new marker.
        junk = 8'h6B;
        for (int k = 0; k < 5; k++) send_bit(junk[k], (k == 0) ? 1'b0 : 1'b1);
        m_cand_vld = 1'b0;
        send_frame(8'h11);
        check("short_ferr", ferr_cnt, 1);
        check("short_po_kept", po, 8'h3D);
        send_frame(8'h11);
        check("11_po", po, 8'h11);

        // Overlong frame: ten extra bit periods with the marker high.
        send_frame(8'hA5);
        for (int k = 0; k < 10; k++) send_bit(k[0], 1'b1);
        m_cand_vld = 1'b0;
        check("long_ferr", ferr_cnt, 2);
        send_frame(8'hA5);
        check("long_po_kept", po, 8'h11);
        send_frame(8'hA5);
        check("long_recover_po", po, 8'hA5);

        // Link loss: sclk stays high after the last rise.
        vld_before = vld_cnt;
        waited = HP;
        while (link_ok === 1'b1 && waited < 80) begin
            tick(1);
            waited++;
        end
        check("tout_not_early", waited >= 60, 1'b1);
        check("tout_in_time", waited <= TOUT + 4, 1'b1);
        while (waited < 70) begin
            tick(1);
            waited++;
        end
        check("tout_po_def", po, DEF);
        check("tout_link_ok", link_ok, 1'b0);
        check("tout_no_vld", vld_cnt, vld_before);
        m_cand_vld = 1'b0;
        send_frame(8'hA5);
        check("tout_first_frame_po", po, DEF);
        send_frame(8'hA5);
        check("tout_recover_po", po, 8'hA5);
        check("tout_recover_link", link_ok, 1'b1);

        // Reset in the middle of a frame.
        junk = 8'h77;
        for (int k = 0; k < 4; k++) send_bit(junk[k], (k == 0) ? 1'b0 : 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_po", po, DEF);
        check("mid_rst_po_vld", po_vld, 1'b0);
        check("mid_rst_frame_err", frame_err, 1'b0);
        check("mid_rst_link_ok", link_ok, 1'b0);
        tick(3);
        rst_n = 1'b1;
        m_cand_vld = 1'b0;
        for (int k = 4; k < 7; k++) send_bit(junk[k], 1'b1);
        check("mid_rst_tail_no_ferr", ferr_cnt, 2);
        send_frame(8'h77);
        check("mid_rst_first_po", po, DEF);
        send_frame(8'h77);
        check("mid_rst_po_77", po, 8'h77);
        check("mid_rst_link", link_ok, 1'b1);

        tick(20);
        check("sb_drained", sb.size(), 0);
        check("vld_total", vld_cnt, n_push);
        check("ferr_total", ferr_cnt, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
